// File: rtl/conv1_sram_ctrl.sv
// FIFO controller over one single-port SRAM (1-cycle registered-address read).
// Optional conflict statistics counter: define CONV1_SRAM_CTRL_STAT_EN.
module conv1_sram_ctrl #(
    parameter int DP = 32,
    parameter int DW = 192,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          sram_cs,
    output logic          sram_we,
    output logic          sram_wem,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,
    output logic [15:0]   stat_conflict_cnt
);

    localparam logic [AW-1:0] LAST  = AW'(DP - 1);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(DP);

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          last_rd_q, last_rd_d;
    logic          rd_valid_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;

    logic wr_elig, rd_elig, conflict, wr_gnt, rd_gnt;

    // Handshake: a write transfers in any cycle where wr_valid & wr_ready; a read is
    // accepted when rd_req & rd_ready, and its data appears with rd_valid one cycle later.
    assign full     = (count_q == DEPTH);
    assign empty    = (count_q == '0);
    assign wr_elig  = wr_valid & ~full;
    assign rd_elig  = rd_req & ~empty;
    assign conflict = wr_elig & rd_elig;

    // On conflict the side not granted last time wins; last_rd_q=1 means read went last.
    assign wr_gnt = rst_n & ~flush & wr_elig & (~rd_elig | last_rd_q);
    assign rd_gnt = rst_n & ~flush & rd_elig & (~wr_elig | ~last_rd_q);

    assign wr_ready  = wr_gnt;
    assign rd_ready  = rd_gnt;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = sram_dout;
    assign count     = count_q;
    assign sram_cs   = wr_gnt | rd_gnt;
    assign sram_we   = wr_gnt;
    assign sram_wem  = wr_gnt;
    assign sram_addr = wr_gnt ? wp_q : (rd_gnt ? rp_q : addr_q);
    assign sram_din  = wr_gnt ? wr_data : din_q;

    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        count_d   = count_q;
        last_rd_d = last_rd_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else if (wr_gnt) begin
            wp_d      = (wp_q == LAST) ? '0 : wp_q + 1'b1;
            count_d   = count_q + 1'b1;
            last_rd_d = 1'b0;
        end else if (rd_gnt) begin
            rp_d      = (rp_q == LAST) ? '0 : rp_q + 1'b1;
            count_d   = count_q - 1'b1;
            last_rd_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            last_rd_q  <= 1'b1;
            rd_valid_q <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            last_rd_q  <= last_rd_d;
            rd_valid_q <= rd_gnt;
            addr_q     <= sram_addr;
            din_q      <= sram_din;
        end
    end

`ifdef CONV1_SRAM_CTRL_STAT_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (flush) begin
            stat_q <= '0;
        end else if (conflict && stat_q != 16'hFFFF) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_conflict_cnt = stat_q;
`else
    assign stat_conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_conv1_sram_ctrl.sv
// Directed bench for conv1_sram_ctrl with a behavioural 1-cycle-read SRAM model.
module tb_conv1_sram_ctrl;
  localparam int DP = 32;
  localparam int DW = 192;
  localparam int AW = 10;

`ifdef CONV1_SRAM_CTRL_STAT_EN
  localparam int EXP_STAT = 6;
`else
  localparam int EXP_STAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          sram_cs;
  logic          sram_we;
  logic          sram_wem;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic [15:0]   stat_conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  conv1_sram_ctrl #(.DP(DP), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_wem(sram_wem),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .stat_conflict_cnt(stat_conflict_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // single-port SRAM, registered-address read
  logic [DW-1:0] mem [DP];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[int'(sram_addr)] <= sram_din;
      else         sram_dout <= mem[int'(sram_addr)];
    end
  end

  // driver helpers: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_valid"}, 256'(rd_valid), 256'd0);
    chk({tag, "_count"}, 256'(count), 256'd0);
    chk({tag, "_empty"}, 256'(empty), 256'd1);
    chk({tag, "_full"}, 256'(full), 256'd0);
    chk({tag, "_wr_ready"}, 256'(wr_ready), 256'd0);
    chk({tag, "_rd_ready"}, 256'(rd_ready), 256'd0);
    chk({tag, "_sram_cs"}, 256'(sram_cs), 256'd0);
    chk({tag, "_sram_we"}, 256'(sram_we), 256'd0);
    chk({tag, "_stat"}, 256'(stat_conflict_cnt), 256'd0);
  endtask

  initial begin
    sram_dout = '0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    wr_valid  = 1'b1;
    rd_req    = 1'b1;
    wr_data   = '0;

    // reset holds everything idle even with requests asserted
    #3;
    chk_reset_vals("rst0");
    tick();
    tick();
    chk_reset_vals("rst1");
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    #1;

    // three writes then three reads
    tick();
    wr_valid = 1'b1; wr_data = DW'(8'hA1); #1;
    chk("w0_ready", 256'(wr_ready), 256'd1);
    chk("w0_cs", 256'(sram_cs), 256'd1);
    chk("w0_we", 256'(sram_we), 256'd1);
    chk("w0_wem", 256'(sram_wem), 256'd1);
    chk("w0_addr", 256'(sram_addr), 256'd0);
    chk("w0_din", 256'(sram_din), 256'hA1);
    tick();
    wr_data = DW'(8'hA2); #1;
    chk("w1_addr", 256'(sram_addr), 256'd1);
    chk("w1_count", 256'(count), 256'd1);
    tick();
    wr_data = DW'(8'hA3); #1;
    chk("w2_addr", 256'(sram_addr), 256'd2);
    tick();
    wr_valid = 1'b0; #1;
    chk("w_count3", 256'(count), 256'd3);
    chk("idle_cs", 256'(sram_cs), 256'd0);
    chk("idle_we", 256'(sram_we), 256'd0);
    chk("idle_addr_hold", 256'(sram_addr), 256'd2);
    chk("idle_din_hold", 256'(sram_din), 256'hA3);
    tick();
    rd_req = 1'b1; #1;
    chk("r0_ready", 256'(rd_ready), 256'd1);
    chk("r0_cs", 256'(sram_cs), 256'd1);
    chk("r0_we", 256'(sram_we), 256'd0);
    chk("r0_addr", 256'(sram_addr), 256'd0);
    chk("r0_valid_pre", 256'(rd_valid), 256'd0);
    tick(); #1;
    chk("r0_valid", 256'(rd_valid), 256'd1);
    chk("r0_data", 256'(rd_data), 256'hA1);
    chk("r1_addr", 256'(sram_addr), 256'd1);
    tick(); #1;
    chk("r1_data", 256'(rd_data), 256'hA2);
    chk("r2_addr", 256'(sram_addr), 256'd2);
    tick();
    rd_req = 1'b0; #1;
    chk("r2_valid", 256'(rd_valid), 256'd1);
    chk("r2_data", 256'(rd_data), 256'hA3);
    chk("r_count0", 256'(count), 256'd0);
    chk("r_empty", 256'(empty), 256'd1);
    tick(); #1;
    chk("r_valid_drop", 256'(rd_valid), 256'd0);

    // fill to full, refuse, then wrap
    tick();
    flush = 1'b1; wr_valid = 1'b1; wr_data = '0; #1;
    chk("flush_wr_block", 256'(wr_ready), 256'd0);
    chk("flush_cs", 256'(sram_cs), 256'd0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < DP; i++) begin
      wr_data = DW'(32'h100 + i); #1;
      if (i == 0 || i == DP - 1) begin
        chk("fill_addr", 256'(sram_addr), 256'(i));
        chk("fill_ready", 256'(wr_ready), 256'd1);
      end
      tick();
    end
    #1;
    chk("full_flag", 256'(full), 256'd1);
    chk("full_count", 256'(count), 256'd32);
    chk("full_refuse", 256'(wr_ready), 256'd0);
    chk("full_cs", 256'(sram_cs), 256'd0);
    rd_req = 1'b1; #1;
    chk("full_rd_ready", 256'(rd_ready), 256'd1);
    chk("full_rd_addr", 256'(sram_addr), 256'd0);
    tick();
    rd_req = 1'b0; wr_data = DW'(32'h33); #1;
    chk("full_rd_data", 256'(rd_data), 256'h100);
    chk("full_rd_valid", 256'(rd_valid), 256'd1);
    chk("wrap_count", 256'(count), 256'd31);
    chk("wrap_ready", 256'(wr_ready), 256'd1);
    chk("wrap_addr", 256'(sram_addr), 256'd0);
    chk("wrap_din", 256'(sram_din), 256'h33);
    tick();
    wr_valid = 1'b0; #1;
    chk("refull", 256'(full), 256'd1);

    // alternating arbitration with count=4 (last grant = read before conflict)
    tick();
    flush = 1'b1; #1;
    tick();
    flush = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = DW'(32'h200 + i);
      tick();
    end
    wr_valid = 1'b0; rd_req = 1'b1;
    tick();
    wr_valid = 1'b1; wr_data = DW'(32'h2FF); #1;
    chk("arb_count_start", 256'(count), 256'd4);
    chk("arb_stat_start", 256'(stat_conflict_cnt), 256'd0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("arb_wr_ready", 256'(wr_ready), 256'((k % 2) == 0));
      chk("arb_rd_ready", 256'(rd_ready), 256'((k % 2) == 1));
      chk("arb_addr", 256'(sram_addr), 256'(((k % 2) == 0) ? (5 + k / 2) : (1 + k / 2)));
      tick();
    end
    wr_valid = 1'b0; rd_req = 1'b0; #1;
    chk("arb_count_end", 256'(count), 256'd4);
    chk("arb_stat", 256'(stat_conflict_cnt), 256'(EXP_STAT));
    chk("arb_last_rd_data", 256'(rd_data), 256'h203);

    // read from empty
    tick();
    flush = 1'b1; #1;
    tick();
    flush = 1'b0; rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("empty_rd_ready", 256'(rd_ready), 256'd0);
      chk("empty_cs", 256'(sram_cs), 256'd0);
      chk("empty_rd_valid", 256'(rd_valid), 256'd0);
      tick();
    end
    chk("flush_stat_clear", 256'(stat_conflict_cnt), 256'd0);
    rd_req = 1'b0;

    // read in N, flush in N+1
    wr_valid = 1'b1; wr_data = DW'(32'h55);
    tick();
    wr_valid = 1'b0; rd_req = 1'b1; #1;
    chk("fl_rd_ready_n", 256'(rd_ready), 256'd1);
    tick();
    flush = 1'b1; wr_valid = 1'b1; #1;
    chk("fl_rd_valid_n1", 256'(rd_valid), 256'd1);
    chk("fl_rd_data_n1", 256'(rd_data), 256'h55);
    chk("fl_no_cs_n1", 256'(sram_cs), 256'd0);
    chk("fl_no_wr_n1", 256'(wr_ready), 256'd0);
    chk("fl_no_rd_n1", 256'(rd_ready), 256'd0);
    tick();
    flush = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; #1;
    chk("fl_count_n2", 256'(count), 256'd0);
    chk("fl_empty_n2", 256'(empty), 256'd1);
    chk("fl_rd_valid_n2", 256'(rd_valid), 256'd0);

    // reset in the cycle after a read grant
    wr_valid = 1'b1; wr_data = DW'(32'h66);
    tick();
    wr_data = DW'(32'h67);
    tick();
    wr_valid = 1'b0; rd_req = 1'b1;
    tick();
    chk("mid_rd_valid_pre", 256'(rd_valid), 256'd1);
    rst_n = 1'b0; wr_valid = 1'b1; #1;
    chk_reset_vals("mid_rst0");
    tick(); #1;
    chk_reset_vals("mid_rst1");
    tick();
    rst_n = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; #1;
    chk("post_rst_count", 256'(count), 256'd0);
    chk("post_rst_empty", 256'(empty), 256'd1);
    tick();
    wr_valid = 1'b1; wr_data = DW'(32'h77); #1;
    chk("post_rst_wr_addr", 256'(sram_addr), 256'd0);
    chk("post_rst_wr_ready", 256'(wr_ready), 256'd1);
    tick();
    wr_valid = 1'b0; #1;
    chk("post_rst_count1", 256'(count), 256'd1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
